throw_controller: RTL and testbench
===================================

// Module: throw_controller
// PURPOSE
//   Upstream stage of the score counter. Conditions the raw start button and pin sensor inputs.
//   Sequences a game of THROWS throws and counts knocked pins in each throw.
//   Emits one glitch-free, one-cycle hit pulse per counted pin; the score counter consumes it.
//   Total hits per game never exceed PINS*THROWS, which is 30 at defaults and fits the 5-bit score.
// PARAMETERS
//   DEBOUNCE_CYCLES  500000    stable-level cycles needed to accept an input change (10 ms @ 50 MHz)
//   SETTLE_CYCLES    50000000  idle cycles after the last pin before the throw closes (1 s)
//   PINS             10        pins per throw
//   THROWS           3         throws per game
// PORTS
//   CLOCK_50     in   1  system clock, all state on posedge
//   resetn       in   1  asynchronous, active-low reset
//   start_n      in   1  raw start button, active-low, asynchronous to the clock
//   pin_n        in   1  raw pin-fall sensor, active-low, asynchronous; one press = one pin
//   hit          out  1  one-cycle pulse per counted pin
//   pins_down    out  4  pins counted in the current or just-closed throw
//   throw_idx    out  2  current throw, 0..THROWS-1
//   throw_active out  1  high while in ROLLING
//   game_over    out  1  high in OVER
// BEHAVIOUR
//   Reset: all outputs are 0; the FSM is in IDLE; timers are cleared. Assertion mid-throw aborts immediately.
//   Input conditioning, per input:
//     - 2-flop synchroniser, then a debounce counter.
//     - The filtered level changes only after DEBOUNCE_CYCLES consecutive equal samples.
//     - A filtered 1->0 transition (press) gives a 1-cycle event: start_ev or pin_ev.
//     - Event latency from a stable raw edge = 2 + DEBOUNCE_CYCLES + 1 cycles.
//   FSM states: IDLE, ROLLING, NEXT, OVER.
//     - IDLE: pin_ev is ignored. start_ev -> ROLLING; pins_down<=0; settle timer <= SETTLE_CYCLES-1.
//     - ROLLING: throw_active=1; start_ev is ignored.
//         - pin_ev with pins_down<PINS: pins_down++, timer reloaded, hit=1 on the next cycle (registered).
//         - pin_ev with pins_down==PINS: dropped, no hit.
//         - Timer counts down when there is no pin_ev.
//         - Timer==0 or pins_down==PINS (strike/spare) -> NEXT.
//     - NEXT: 1 cycle. If throw_idx==THROWS-1 -> OVER; else throw_idx++ and -> IDLE. pins_down holds.
//     - OVER: game_over=1, pin_ev is ignored. start_ev -> IDLE with throw_idx<=0, pins_down<=0, game_over<=0.
//   Simultaneous events:
//     - pin_ev and start_ev in the same cycle: each is judged only by the current state.
//     - pin_ev in the same cycle the timer reaches 0: the pin is counted and the timer reloads (stays ROLLING).
//   hit is never asserted in consecutive cycles. Pins are counted at most one per debounce window.
//   Widths: pins_down saturates at PINS, no wrap. throw_idx never exceeds THROWS-1. Timers are $clog2-sized.
// CONFIGURATION
//   THROW_DEBOUNCE_EN defined:
//     - Debounce counters are built as above.
//   THROW_DEBOUNCE_EN undefined:
//     - Counters are removed and DEBOUNCE_CYCLES is unused.
//     - Events come from the edge of the synchronised level.
//     - Latency from a raw edge = 3 cycles. Intended for fast simulation and clean sensors.
//   FSM behaviour is identical in both builds.
// STRUCTURE
//   Package throw_pkg holds:
//     - state enum {IDLE, ROLLING, NEXT, OVER}
//     - default constants PINS=10, THROWS=3
//     - pins_t (4-bit) and idx_t (2-bit) typedefs
//   Sub-module debounce_edge (synchroniser + optional debounce + press-edge pulse), instantiated for start_n and pin_n.
//   FSM, settle timer, pins_down and throw_idx live in throw_controller.
// TESTING  (bench: DEBOUNCE_CYCLES=4, SETTLE_CYCLES=20)
//   1. resetn low then high, no input:
//      all outputs 0, FSM stays IDLE for 100 cycles.
//   2. start press, then 3 clean pin presses 10 cycles apart:
//      3 single-cycle hit pulses, pins_down=3, throw closes 20 cycles after the last pin, throw_idx=1.
//   3. pin_n bouncing 0/1 every cycle for 3 cycles, then held low:
//      exactly 1 hit (debounce build); without THROW_DEBOUNCE_EN the bench checks >=1 hit.
//   4. 12 pin presses in one throw:
//      10 hits; NEXT is entered right after the 10th; presses 11-12 give no hit.
//   5. 3 full throws of 10 pins:
//      30 hits total, game_over=1, pins ignored; start press -> throw_idx=0, game_over=0.
//   6. resetn pulsed low mid-ROLLING with pins_down=5:
//      outputs clear asynchronously, FSM in IDLE, no hit after release.

Source files
------------

// File: rtl/throw_pkg.sv
// Shared types and defaults for the throw controller.
// THROW_DEBOUNCE_EN selects the debounced input build.
package throw_pkg;

  localparam int DEF_PINS   = 10;
  localparam int DEF_THROWS = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    NEXT    = 2'd2,
    OVER    = 2'd3
  } state_t;

  typedef logic [3:0] pins_t;
  typedef logic [1:0] idx_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_edge.sv
// Synchroniser, optional debounce filter (THROW_DEBOUNCE_EN) and press-edge pulse
// for one active-low asynchronous input.
module debounce_edge
`ifdef THROW_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
)
`endif
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_n_i,
  output logic press_o
);

  logic [1:0] sync_q;
  logic       lvl;
  logic       lvl_p_q;

  // Released level (1) is the reset value so reset release never looks like a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], raw_n_i};
  end

`ifdef THROW_DEBOUNCE_EN
  import throw_pkg::*;

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Any sample equal to the filtered level restarts the run of differing samples.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_q[1] == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      filt_d = sync_q[1];
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[1];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lvl_p_q <= 1'b1;
    else         lvl_p_q <= lvl;
  end

  assign press_o = lvl_p_q & ~lvl;

endmodule

// File: rtl/throw_controller.sv
// Conditions start/pin inputs and sequences a game of THROWS throws, emitting one
// registered hit pulse per counted pin. THROW_DEBOUNCE_EN enables input debouncing.
module throw_controller
  import throw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SETTLE_CYCLES   = 50000000,
  parameter int unsigned PINS            = DEF_PINS,
  parameter int unsigned THROWS          = DEF_THROWS
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start_n,
  input  logic       pin_n,
  output logic       hit,
  output logic [3:0] pins_down,
  output logic [1:0] throw_idx,
  output logic       throw_active,
  output logic       game_over
);

  localparam int unsigned TW = cnt_width(SETTLE_CYCLES);
  localparam logic [TW-1:0] RELOAD   = TW'(SETTLE_CYCLES - 1);
  localparam pins_t         PINS_MAX = pins_t'(PINS);
  localparam idx_t          LAST_IDX = idx_t'(THROWS - 1);

  logic start_ev, pin_ev;

`ifdef THROW_DEBOUNCE_EN
  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk_i(CLOCK_50), .rst_ni(resetn), .raw_n_i(start_n), .press_o(start_ev)
  );
  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pin (
    .clk_i(CLOCK_50), .rst_ni(resetn), .raw_n_i(pin_n), .press_o(pin_ev)
  );
`else
  debounce_edge u_start (
    .clk_i(CLOCK_50), .rst_ni(resetn), .raw_n_i(start_n), .press_o(start_ev)
  );
  debounce_edge u_pin (
    .clk_i(CLOCK_50), .rst_ni(resetn), .raw_n_i(pin_n), .press_o(pin_ev)
  );
`endif

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  pins_t         pins_q,  pins_d;
  idx_t          idx_q,   idx_d;
  logic          hit_q,   hit_d;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      timer_q <= '0;
      pins_q  <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pins_q  <= pins_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pins_d  = pins_q;
    idx_d   = idx_q;
    hit_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ev) begin
          state_d = ROLLING;
          pins_d  = '0;
          timer_d = RELOAD;
        end
      end
      ROLLING: begin
        // A pin arriving as the timer expires wins: it is counted and reopens the window.
        if (pin_ev && (pins_q < PINS_MAX)) begin
          pins_d  = pins_q + 1'b1;
          timer_d = RELOAD;
          hit_d   = 1'b1;
          if (pins_q + 1'b1 == PINS_MAX) state_d = NEXT;
        end else if ((pins_q == PINS_MAX) || (timer_q == '0)) begin
          state_d = NEXT;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = OVER;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = IDLE;
        end
      end
      OVER: begin
        if (start_ev) begin
          state_d = IDLE;
          idx_d   = '0;
          pins_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    throw_active = (state_q == ROLLING);
    game_over    = (state_q == OVER);
  end

  assign hit       = hit_q;
  assign pins_down = pins_q;
  assign throw_idx = idx_q;

endmodule

// File: tb/tb_throw_controller.sv
// Directed + randomized game sequences for throw_controller, scored against a
// throw-level model (hits per throw = min(presses, 10), 3 throws per game).
module tb_throw_controller;

  localparam int DEB = 4;
  localparam int SET = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_n = 1'b1;
  logic       pin_n = 1'b1;
  logic       hit, throw_active, game_over;
  logic [3:0] pins_down;
  logic [1:0] throw_idx;

  int vectors = 0;
  int miscompares = 0;

  int   cyc = 0, hit_cnt = 0, last_hit_cyc = 0, fall_cyc = 0, consec = 0;
  logic hit_prev = 1'b0, act_prev = 1'b0;

  always #5 clk = ~clk;

  throw_controller #(
    .DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SET), .PINS(10), .THROWS(3)
  ) dut (
    .CLOCK_50(clk), .resetn(rst_n), .start_n(start_n), .pin_n(pin_n),
    .hit(hit), .pins_down(pins_down), .throw_idx(throw_idx),
    .throw_active(throw_active), .game_over(game_over)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (hit) begin
      hit_cnt = hit_cnt + 1;
      last_hit_cyc = cyc;
      if (hit_prev) consec = consec + 1;
    end
    if (act_prev && !throw_active) fall_cyc = cyc;
    hit_prev = hit;
    act_prev = throw_active;
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press_pin(input int gap);
    pin_n = 1'b0;
    tick(5);
    pin_n = 1'b1;
    tick(gap - 5);
  endtask

  task automatic press_start();
    start_n = 1'b0;
    tick(5);
    start_n = 1'b1;
    tick(5);
  endtask

  task automatic wait_close(input string tag);
    int n;
    n = 0;
    while (throw_active && n < 200) begin
      tick(1);
      n++;
    end
    check(tag, int'(throw_active), 0);
    tick(3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, busy, n, gap, exp_hits, total;

    // 1: reset, quiet idle, pin ignored in IDLE
    #1 rst_n = 1'b0;
    tick(2);
    check("reset_outputs", int'({hit, pins_down, throw_idx, throw_active, game_over}), 0);
    rst_n = 1'b1;
    busy = 0;
    repeat (100) begin
      tick(1);
      if ({hit, pins_down, throw_idx, throw_active, game_over} != 9'd0) busy++;
    end
    check("idle_100_cycles", busy, 0);
    h0 = hit_cnt;
    press_pin(10);
    tick(5);
    check("idle_pin_ignored", hit_cnt - h0, 0);

    // 2: three clean pins, throw closes SET cycles after the last one
    press_start();
    check("start_rolling", int'(throw_active), 1);
    check("start_pins_zero", int'(pins_down), 0);
    h0 = hit_cnt;
    repeat (3) press_pin(10);
    check("three_pins_hits", hit_cnt - h0, 3);
    check("three_pins_count", int'(pins_down), 3);
    wait_close("three_pins_close_timeout");
    check("settle_latency", fall_cyc - last_hit_cyc, SET);
    check("throw_idx_after_1", int'(throw_idx), 1);
    check("pins_hold_after_close", int'(pins_down), 3);

    // 3: bouncing pin
    press_start();
    h0 = hit_cnt;
    pin_n = 1'b0; tick(1);
    pin_n = 1'b1; tick(1);
    pin_n = 1'b0; tick(8);
    pin_n = 1'b1; tick(8);
`ifdef THROW_DEBOUNCE_EN
    check("bounce_single_hit", hit_cnt - h0, 1);
`else
    check("bounce_at_least_one_hit", int'(hit_cnt - h0 >= 1), 1);
`endif
    wait_close("bounce_close_timeout");
    check("throw_idx_after_2", int'(throw_idx), 2);

    // 4: 12 presses, saturate at 10, last throw ends the game
    press_start();
    h0 = hit_cnt;
    repeat (12) press_pin(10);
    check("strike_hits", hit_cnt - h0, 10);
    check("strike_next_immediate", fall_cyc - last_hit_cyc, 0);
    check("strike_pins_saturate", int'(pins_down), 10);
    check("strike_game_over", int'(game_over), 1);
    h0 = hit_cnt;
    press_pin(10);
    check("over_pin_ignored", hit_cnt - h0, 0);
    press_start();
    check("restart_game_over_clear", int'(game_over), 0);
    check("restart_idx_zero", int'(throw_idx), 0);
    check("restart_pins_zero", int'(pins_down), 0);

    // 5: three full throws of 10 pins with random spacing
    h0 = hit_cnt;
    for (int t = 0; t < 3; t++) begin
      press_start();
      for (int p = 0; p < 10; p++) press_pin(int'($urandom_range(10, 18)));
      wait_close("full_close_timeout");
    end
    check("full_game_hits", hit_cnt - h0, 30);
    check("full_game_over", int'(game_over), 1);
    h0 = hit_cnt;
    press_pin(12);
    check("full_over_pin_ignored", hit_cnt - h0, 0);
    press_start();
    check("full_restart_idx", int'(throw_idx), 0);
    check("full_restart_over", int'(game_over), 0);

    // randomized game against the throw-level model
    total = hit_cnt;
    for (int t = 0; t < 3; t++) begin
      n = int'($urandom_range(0, 12));
      exp_hits = (n < 10) ? n : 10;
      press_start();
      h0 = hit_cnt;
      for (int p = 0; p < n; p++) begin
        gap = int'($urandom_range(10, 16));
        press_pin(gap);
      end
      wait_close("rand_close_timeout");
      check("rand_throw_hits", hit_cnt - h0, exp_hits);
      check("rand_throw_pins", int'(pins_down), exp_hits);
      check("rand_throw_idx", int'(throw_idx), (t < 2) ? t + 1 : 2);
      check("rand_game_over", int'(game_over), (t < 2) ? 0 : 1);
    end
    check("rand_game_total_le_30", int'(hit_cnt - total <= 30), 1);
    press_start();

    // 6: asynchronous reset in the middle of a throw
    press_start();
    repeat (5) press_pin(10);
    check("midthrow_pins", int'(pins_down), 5);
    check("midthrow_active", int'(throw_active), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({hit, pins_down, throw_idx, throw_active, game_over}), 0);
    tick(3);
    rst_n = 1'b1;
    h0 = hit_cnt;
    tick(30);
    check("post_reset_no_hit", hit_cnt - h0, 0);
    check("post_reset_idle", int'({throw_active, throw_idx, pins_down}), 0);

    check("no_back_to_back_hits", consec, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
